uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with an on-chip transmit FIFO. Serialises frames
//  of the form start, DATA_WIDTH data bits (LSB first), optional parity, 1 or 2 stops.

---
 rtl/uart_tx_fifo.sv | 219 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small circular TX FIFO.
// Each frame is a start bit, DATA_WIDTH data bits sent LSB first, an optional
// parity bit and then one or two stop bits. The parity mode and stop count are
// captured when a word is popped from the FIFO.
// Ports:
//   i_clock, i_reset   system clock and synchronous active-high reset
//   i_tick             baud oversample strobe; OVERSAMPLE ticks make one bit
//   i_data, i_valid    host push; a word is accepted when i_valid & o_ready
//   o_ready            FIFO is not full
//   i_parity_mode      00/11 none, 01 even, 10 odd
//   i_stop_two         1 selects two stop bits, 0 selects one
//   o_tx               registered serial line, high when idle
//   o_busy             high from START through STOP
//   o_done             one-clock pulse when a frame ends
//   o_fifo_count       number of words held in the FIFO
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_tick,
    input  logic [DATA_WIDTH-1:0]             i_data,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [1:0]                        i_parity_mode,
    input  logic                              i_stop_two,
    output logic                              o_tx,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH);

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_START  = 5'b00010;
    localparam logic [4:0] S_DATA   = 5'b00100;
    localparam logic [4:0] S_PARITY = 5'b01000;
    localparam logic [4:0] S_STOP   = 5'b10000;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [4:0]            state_q,      state_d;
    logic [PTR_W-1:0]      wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]      count_q,      count_d;
    logic                  ready_q,      ready_d;
    logic [DATA_WIDTH-1:0] shift_q,      shift_d;
    logic                  parity_bit_q, parity_bit_d;
    logic                  has_parity_q, has_parity_d;
    logic                  stop_two_q,   stop_two_d;
    logic                  stop_idx_q,   stop_idx_d;
    logic [TICK_W-1:0]     tick_q,       tick_d;
    logic [BIT_W-1:0]      bit_q,        bit_d;
    logic                  tx_q,         tx_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;

    logic                  push_c;
    logic                  pop_c;
    logic                  bit_end_c;
    logic [DATA_WIDTH-1:0] head_c;

    assign o_ready      = ready_q;
    assign o_tx         = tx_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_fifo_count = count_q;

    // ready_q mirrors count_q < FIFO_DEPTH, so a push while full is dropped
    // even when a pop frees a slot in the same cycle.
    assign push_c    = i_valid & ready_q;
    assign head_c    = mem[rd_ptr_q];
    assign bit_end_c = i_tick && (tick_q == TICK_W'(OVERSAMPLE - 1));

    // Next-state, FIFO bookkeeping and serial output.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        shift_d      = shift_q;
        parity_bit_d = parity_bit_q;
        has_parity_d = has_parity_q;
        stop_two_d   = stop_two_q;
        stop_idx_d   = stop_idx_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        done_d       = 1'b0;
        pop_c        = 1'b0;

        // Every state change happens on bit_end or out of IDLE, so the
        // counter is always zero on state entry.
        if (i_tick) begin
            tick_d = bit_end_c ? '0 : tick_q + TICK_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (count_q != '0) begin
                    pop_c        = 1'b1;
                    shift_d      = head_c;
                    has_parity_d = (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
                    parity_bit_d = (^head_c) ^ (i_parity_mode == 2'b10);
                    stop_two_d   = i_stop_two;
                    stop_idx_d   = 1'b0;
                    bit_d        = '0;
                    state_d      = S_START;
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = has_parity_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end_c) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end_c) begin
                    if (stop_two_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d < CNT_W'(FIFO_DEPTH));

        // Line level is derived from the state being entered so o_tx is a flop.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_bit_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Control and datapath registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ready_q      <= 1'b1;
            shift_q      <= '0;
            parity_bit_q <= 1'b0;
            has_parity_q <= 1'b0;
            stop_two_q   <= 1'b0;
            stop_idx_q   <= 1'b0;
            tick_q       <= '0;
            bit_q        <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            shift_q      <= shift_d;
            parity_bit_q <= parity_bit_d;
            has_parity_q <= has_parity_d;
            stop_two_q   <= stop_two_d;
            stop_idx_q   <= stop_idx_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers are cleared.
    always_ff @(posedge i_clock) begin
        if (push_c) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo.
// Expected frames are built from the word, parity mode and stop count as a
// plain list of line levels; each level is checked mid-bit by counting ticks.
module tb_uart_tx_fifo;

    localparam int unsigned DW = 8;
    localparam int unsigned OS = 16;
    localparam int unsigned FD = 4;

    logic          i_clock;
    logic          i_reset;
    logic          i_tick;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [1:0]    i_parity_mode;
    logic          i_stop_two;
    logic          o_tx;
    logic          o_busy;
    logic          o_done;
    logic [2:0]    o_fifo_count;

    int   checks;
    int   errors;
    logic tick_en;

    uart_tx_fifo #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .FIFO_DEPTH(FD)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_tick        (i_tick),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_parity_mode (i_parity_mode),
        .i_stop_two    (i_stop_two),
        .o_tx          (o_tx),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_fifo_count  (o_fifo_count)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Tick strobe every second clock while enabled.
    always @(posedge i_clock) begin
        #1;
        if (tick_en) i_tick = ~i_tick;
        else         i_tick = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_raw(input logic [DW-1:0] d);
        i_data  = d;
        i_valid = 1'b1;
        @(negedge i_clock);
        i_valid = 1'b0;
    endtask

    // Push into an empty idle transmitter and check the two-clock start latency.
    task automatic push_idle(input logic [DW-1:0] d);
        push_raw(d);
        chk("lat_count1", 32'(o_fifo_count), 32'd1);
        chk("lat_tx_idle", 32'(o_tx), 32'd1);
        chk("lat_busy0", 32'(o_busy), 32'd0);
        @(negedge i_clock);
        chk("lat_count0", 32'(o_fifo_count), 32'd0);
        chk("lat_tx_start", 32'(o_tx), 32'd0);
        chk("lat_busy1", 32'(o_busy), 32'd1);
    endtask

    // action 1: switch parity mode mid-frame; action 2: reset during data bit 3.
    task automatic check_frame(input logic [DW-1:0] d, input logic [1:0] mode,
                               input logic stop2, input int exp_wait,
                               input int action, input logic [1:0] new_mode);
        logic exp_bits[$];
        int   n;
        int   cnt;
        int   guard;
        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int i = 0; i < int'(DW); i++) exp_bits.push_back(d[i]);
        if (mode == 2'b01)      exp_bits.push_back(^d);
        else if (mode == 2'b10) exp_bits.push_back(~^d);
        exp_bits.push_back(1'b1);
        if (stop2) exp_bits.push_back(1'b1);

        n = 0;
        while (o_tx !== 1'b0 && n < 400) begin
            @(negedge i_clock);
            n++;
        end
        if (n >= 400) begin
            chk("start_timeout", 32'(o_tx), 32'd0);
            return;
        end
        if (exp_wait >= 0) chk("idle_gap", 32'(n), 32'(exp_wait));

        guard = 0;
        for (int b = 0; b < exp_bits.size(); b++) begin
            cnt = 0;
            while (cnt < int'(OS)) begin
                if (i_tick) begin
                    cnt++;
                    if (cnt == int'(OS / 2)) begin
                        chk($sformatf("tx_bit%0d", b), 32'(o_tx), 32'(exp_bits[b]));
                        chk("busy_mid", 32'(o_busy), 32'd1);
                        chk("done_mid", 32'(o_done), 32'd0);
                        if (action == 1 && b == 4) i_parity_mode = new_mode;
                        if (action == 2 && b == 4) begin
                            i_reset = 1'b1;
                            @(negedge i_clock);
                            i_reset = 1'b0;
                            chk("rst_tx", 32'(o_tx), 32'd1);
                            chk("rst_busy", 32'(o_busy), 32'd0);
                            chk("rst_count", 32'(o_fifo_count), 32'd0);
                            chk("rst_done", 32'(o_done), 32'd0);
                            chk("rst_ready", 32'(o_ready), 32'd1);
                            return;
                        end
                    end
                end
                @(negedge i_clock);
                guard++;
                if (guard > 20000) begin
                    chk("bit_timeout", 32'(guard), 32'd0);
                    return;
                end
            end
        end
        chk("done_end", 32'(o_done), 32'd1);
        chk("busy_end", 32'(o_busy), 32'd0);
        chk("tx_end", 32'(o_tx), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] w0;
        logic [DW-1:0] d;
        logic [DW-1:0] q[$];
        int            mcount;
        int            dn;
        int            lo;
        logic [1:0]    m;
        logic          s;

        checks        = 0;
        errors        = 0;
        tick_en       = 1'b0;
        i_tick        = 1'b0;
        i_reset       = 1'b1;
        i_data        = '0;
        i_valid       = 1'b0;
        i_parity_mode = 2'b00;
        i_stop_two    = 1'b0;
        repeat (3) @(negedge i_clock);
        chk("reset_tx", 32'(o_tx), 32'd1);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_done", 32'(o_done), 32'd0);
        chk("reset_count", 32'(o_fifo_count), 32'd0);
        chk("reset_ready", 32'(o_ready), 32'd1);
        i_reset = 1'b0;
        tick_en = 1'b1;
        @(negedge i_clock);

        // Plain frame, then even and odd parity, then two stop bits.
        push_idle(8'hA5);
        check_frame(8'hA5, 2'b00, 1'b0, 0, 0, 2'b00);
        i_parity_mode = 2'b01;
        push_idle(8'hA5);
        check_frame(8'hA5, 2'b01, 1'b0, 0, 0, 2'b00);
        i_parity_mode = 2'b10;
        push_idle(8'hA5);
        check_frame(8'hA5, 2'b10, 1'b0, 0, 0, 2'b00);
        i_parity_mode = 2'b00;
        i_stop_two    = 1'b1;
        push_idle(8'h00);
        check_frame(8'h00, 2'b00, 1'b1, 0, 0, 2'b00);

        // Fill the FIFO while the first frame is stalled for lack of ticks.
        i_parity_mode = 2'b01;
        i_stop_two    = 1'b1;
        tick_en       = 1'b0;
        w0 = 8'($urandom);
        push_idle(w0);
        mcount = 0;
        q = {};
        for (int k = 0; k < 5; k++) begin
            d = 8'($urandom);
            push_raw(d);
            if (mcount < int'(FD)) begin
                mcount++;
                q.push_back(d);
            end
            chk("fill_count", 32'(o_fifo_count), 32'(mcount));
            chk("fill_ready", 32'(o_ready), 32'(mcount < int'(FD)));
        end
        tick_en = 1'b1;
        check_frame(w0, 2'b01, 1'b1, 0, 0, 2'b00);
        foreach (q[i]) check_frame(q[i], 2'b01, 1'b1, 1, 0, 2'b00);

        // Config change mid-frame only affects the following frame.
        i_parity_mode = 2'b01;
        i_stop_two    = 1'b0;
        tick_en       = 1'b0;
        w0 = 8'($urandom);
        d  = 8'($urandom);
        push_idle(w0);
        push_raw(d);
        tick_en = 1'b1;
        check_frame(w0, 2'b01, 1'b0, 0, 1, 2'b10);
        check_frame(d, 2'b10, 1'b0, 1, 0, 2'b00);

        // Reset during data bit 3 aborts the frame and flushes the FIFO.
        i_parity_mode = 2'b00;
        tick_en       = 1'b0;
        w0 = 8'($urandom);
        push_idle(w0);
        push_raw(8'($urandom));
        push_raw(8'($urandom));
        tick_en = 1'b1;
        check_frame(w0, 2'b00, 1'b0, 0, 2, 2'b00);
        dn = 0;
        lo = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clock);
            if (o_done) dn++;
            if (!o_tx) lo++;
        end
        chk("post_rst_done", 32'(dn), 32'd0);
        chk("post_rst_tx_low", 32'(lo), 32'd0);

        // Random words and configurations.
        repeat (6) begin
            m = 2'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            i_parity_mode = m;
            i_stop_two    = s;
            push_idle(d);
            check_frame(d, m, s, 0, 0, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
